// File: rtl/app_fracture_if.sv
// Ring-sample / fracture-status bundle between the acquisition front ends,
// app_fracture and app_reg.
interface app_fracture_if;
    logic [127:0] ph_ring;
    logic [7:0]   ph_vld;
    logic [15:0]  cfg_ring_th;
    logic [7:0]   clr_fracture;
    logic [7:0]   stu_fracture;
    logic [7:0]   frac_evt;
    logic         frac_irq;

    modport master (
        output ph_ring, ph_vld, cfg_ring_th, clr_fracture,
        input  stu_fracture, frac_evt, frac_irq
    );

    modport slave (
        input  ph_ring, ph_vld, cfg_ring_th, clr_fracture,
        output stu_fracture, frac_evt, frac_irq
    );
endinterface

// File: rtl/app_fracture.sv
// Eight independent debounced ring-level fracture detectors with sticky status.
// Define APP_FRAC_IRQ_EN to build the registered frac_irq level; otherwise frac_irq is 0.
module app_fracture #(
    parameter int unsigned DEB_N = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    app_fracture_if.slave  bus
);

    typedef enum logic [1:0] {ARMED, COUNTING, LATCHED} state_t;

    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_N);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t           st_q  [8];
    logic [CNT_W-1:0] cnt_q [8];
    logic [7:0]       stu_q;
    logic [7:0]       evt_q;
    logic [7:0]       below_d;

    // Equal-to-threshold is not below, so a zero threshold can never fracture.
    always_comb begin
        below_d = '0;
        for (int k = 0; k < 8; k++) begin
            below_d[k] = bus.ph_ring[16*k +: 16] < bus.cfg_ring_th;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stu_q <= '0;
            evt_q <= '0;
            for (int k = 0; k < 8; k++) begin
                st_q[k]  <= ARMED;
                cnt_q[k] <= '0;
            end
        end else begin
            evt_q <= '0;
            for (int k = 0; k < 8; k++) begin
                // Clear takes priority over any sample arriving in the same cycle.
                if (bus.clr_fracture[k]) begin
                    st_q[k]  <= ARMED;
                    cnt_q[k] <= '0;
                    stu_q[k] <= 1'b0;
                end else begin
                    case (st_q[k])
                        ARMED: begin
                            if (bus.ph_vld[k] && below_d[k]) begin
                                if (DEB_N == 1) begin
                                    st_q[k]  <= LATCHED;
                                    cnt_q[k] <= DEB_C;
                                    stu_q[k] <= 1'b1;
                                    evt_q[k] <= 1'b1;
                                end else begin
                                    st_q[k]  <= COUNTING;
                                    cnt_q[k] <= ONE_C;
                                end
                            end
                        end
                        COUNTING: begin
                            if (bus.ph_vld[k]) begin
                                if (!below_d[k]) begin
                                    st_q[k]  <= ARMED;
                                    cnt_q[k] <= '0;
                                end else if (cnt_q[k] + ONE_C == DEB_C) begin
                                    st_q[k]  <= LATCHED;
                                    cnt_q[k] <= DEB_C;
                                    stu_q[k] <= 1'b1;
                                    evt_q[k] <= 1'b1;
                                end else begin
                                    cnt_q[k] <= cnt_q[k] + ONE_C;
                                end
                            end
                        end
                        default: ; // LATCHED holds until cleared
                    endcase
                end
            end
        end
    end

    assign bus.stu_fracture = stu_q;
    assign bus.frac_evt     = evt_q;

`ifdef APP_FRAC_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |stu_q;
        end
    end

    assign bus.frac_irq = irq_q;
`else
    assign bus.frac_irq = 1'b0;
`endif

endmodule

// File: tb/tb_app_fracture.sv
// Scoreboard bench for app_fracture: a per-channel behavioural model queues the
// expected status/event/irq per cycle, popped and compared one step later.
module tb_app_fracture;

    localparam int DEB_N = 4;
`ifdef APP_FRAC_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] stu;
        logic [7:0] evt;
        logic       irq;
    } exp_t;

    logic clk_sys;
    logic rst_n;
    app_fracture_if bus();

    app_fracture #(.DEB_N(DEB_N), .CNT_W(8)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int         n_chk;
    int         n_err;
    exp_t       sb_q[$];
    int         m_run [8];
    logic [7:0] m_stu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_run[k] = 0;
        m_stu = '0;
    endtask

    // One clock with the current ring/threshold, given vld and clr vectors.
    task automatic step(input logic [7:0] vld, input logic [7:0] clr);
        exp_t e;
        exp_t got;
        logic [7:0] evt;
        bus.ph_vld       = vld;
        bus.clr_fracture = clr;
        e.irq = IRQ_EN ? (|m_stu) : 1'b0;
        evt = '0;
        for (int k = 0; k < 8; k++) begin
            if (clr[k]) begin
                m_run[k] = 0;
                m_stu[k] = 1'b0;
            end else if (!m_stu[k] && vld[k]) begin
                if (bus.ph_ring[16*k +: 16] < bus.cfg_ring_th) begin
                    m_run[k]++;
                    if (m_run[k] == DEB_N) begin
                        m_stu[k] = 1'b1;
                        evt[k]   = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
        end
        e.stu = m_stu;
        e.evt = evt;
        sb_q.push_back(e);
        @(posedge clk_sys);
        #1;
        got = sb_q.pop_front();
        chk("sb_stu", bus.stu_fracture, got.stu);
        chk("sb_evt", bus.frac_evt, got.evt);
        chk("sb_irq", bus.frac_irq, got.irq);
        bus.ph_vld       = '0;
        bus.clr_fracture = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 8'h00);
    endtask

    task automatic samp(input int ch, input logic [15:0] val, input logic [7:0] clr);
        bus.ph_ring[16*ch +: 16] = val;
        step(8'h01 << ch, clr);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_reset();
        bus.ph_ring      = '0;
        bus.ph_vld       = '0;
        bus.cfg_ring_th  = 16'h0100;
        bus.clr_fracture = '0;
        rst_n            = 1'b0;
        #12;
        chk("rst_stu", bus.stu_fracture, 8'h00);
        chk("rst_evt", bus.frac_evt, 8'h00);
        chk("rst_irq", bus.frac_irq, 1'b0);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // Channel 1 fracture, then clear.
        for (int i = 0; i < 4; i++) samp(0, 16'h00FF, 8'h00);
        chk("ch1_stu", bus.stu_fracture, 8'h01);
        chk("ch1_evt", bus.frac_evt, 8'h01);
        idle(1);
        chk("ch1_evt_once", bus.frac_evt, 8'h00);
        chk("ch1_irq", bus.frac_irq, IRQ_EN);
        step(8'h00, 8'h01);
        idle(2);
        chk("ch1_cleared", bus.stu_fracture, 8'h00);

        // Channel 3 run broken by an above-threshold sample.
        samp(2, 16'h0050, 8'h00);
        samp(2, 16'h0050, 8'h00);
        samp(2, 16'h0200, 8'h00);
        for (int i = 0; i < 3; i++) samp(2, 16'h0050, 8'h00);
        chk("ch3_no_frac", bus.stu_fracture, 8'h00);
        samp(2, 16'h0050, 8'h00);
        chk("ch3_frac", bus.stu_fracture, 8'h04);
        step(8'h00, 8'h04);

        // Channel 8 with vld gaps; channel 5 idle for 1000 cycles.
        for (int i = 0; i < 4; i++) begin
            samp(7, 16'h0001, 8'h00);
            if (i < 3) idle(10);
        end
        chk("ch8_gap_frac", bus.stu_fracture, 8'h80);
        step(8'h00, 8'h80);
        idle(1000);
        chk("ch5_idle", bus.stu_fracture[4], 1'b0);

        // Channel 2 clear colliding with a below sample.
        for (int i = 0; i < 4; i++) samp(1, 16'h00FF, 8'h00);
        chk("ch2_latched", bus.stu_fracture, 8'h02);
        samp(1, 16'h00FF, 8'h02);
        chk("ch2_clr_stu", bus.stu_fracture, 8'h00);
        chk("ch2_clr_evt", bus.frac_evt, 8'h00);
        for (int i = 0; i < 3; i++) samp(1, 16'h00FF, 8'h00);
        chk("ch2_restart", bus.stu_fracture, 8'h00);
        samp(1, 16'h00FF, 8'h00);
        chk("ch2_reset_stu", bus.stu_fracture, 8'h02);
        chk("ch2_reset_evt", bus.frac_evt, 8'h02);
        step(8'h00, 8'h02);

        // Threshold boundaries.
        bus.cfg_ring_th = 16'h0000;
        for (int i = 0; i < 10; i++) samp(0, 16'h0000, 8'h00);
        chk("th0_never", bus.stu_fracture, 8'h00);
        bus.cfg_ring_th = 16'h0100;
        for (int i = 0; i < 4; i++) samp(0, 16'h0100, 8'h00);
        chk("th_equal", bus.stu_fracture, 8'h00);
        bus.cfg_ring_th = 16'hFFFF;
        for (int i = 0; i < 4; i++) samp(0, 16'hFFFF, 8'h00);
        chk("thmax_equal", bus.stu_fracture, 8'h00);
        for (int i = 0; i < 4; i++) samp(0, 16'hFFFE, 8'h00);
        chk("thmax_frac", bus.stu_fracture, 8'h01);
        step(8'h00, 8'h01);
        idle(2);

        // Asynchronous reset in the middle of runs on every channel.
        bus.cfg_ring_th = 16'h0100;
        for (int k = 0; k < 8; k++) bus.ph_ring[16*k +: 16] = 16'h0050;
        for (int i = 0; i < 3; i++) step(8'hFF, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_stu", bus.stu_fracture, 8'h00);
        chk("midrst_evt", bus.frac_evt, 8'h00);
        chk("midrst_irq", bus.frac_irq, 1'b0);
        model_reset();
        #1 rst_n = 1'b1;
        step(8'hFF, 8'h00);
        chk("postrst_one", bus.stu_fracture, 8'h00);
        for (int i = 0; i < 3; i++) step(8'hFF, 8'h00);
        chk("postrst_stu", bus.stu_fracture, 8'hFF);
        chk("postrst_evt", bus.frac_evt, 8'hFF);
        idle(1);
        chk("postrst_irq", bus.frac_irq, IRQ_EN);
        step(8'h00, 8'hFF);
        idle(2);
        chk("final_irq", bus.frac_irq, 1'b0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
